// File: rtl/mem_req_arbiter_if.sv
// Command-port bundle between the AXI read/write paths, the arbiter and the SDRAM controller.
// The slave modport is the arbiter view. The master modport is the surrounding-logic view.
interface mem_req_arbiter_if #(
    parameter int unsigned ADDRS = 32,
    parameter int unsigned REQID = 4
);
    logic             wr_store_i;
    logic             wr_accept_o;
    logic             wr_seq_i;
    logic [REQID-1:0] wr_id_i;
    logic [ADDRS-1:0] wr_addr_i;
    logic             rd_fetch_i;
    logic             rd_accept_o;
    logic             rd_seq_i;
    logic [REQID-1:0] rd_id_i;
    logic [ADDRS-1:0] rd_addr_i;
    logic             ctl_req_o;
    logic             ctl_rdy_i;
    logic             ctl_wrn_o;
    logic             ctl_seq_o;
    logic [REQID-1:0] ctl_id_o;
    logic [ADDRS-1:0] ctl_addr_o;

    modport master (
        output wr_store_i, wr_seq_i, wr_id_i, wr_addr_i,
        output rd_fetch_i, rd_seq_i, rd_id_i, rd_addr_i, ctl_rdy_i,
        input  wr_accept_o, rd_accept_o,
        input  ctl_req_o, ctl_wrn_o, ctl_seq_o, ctl_id_o, ctl_addr_o
    );

    modport slave (
        input  wr_store_i, wr_seq_i, wr_id_i, wr_addr_i,
        input  rd_fetch_i, rd_seq_i, rd_id_i, rd_addr_i, ctl_rdy_i,
        output wr_accept_o, rd_accept_o,
        output ctl_req_o, ctl_wrn_o, ctl_seq_o, ctl_id_o, ctl_addr_o
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares the SDRAM controller command port between the AXI write and read paths.
// Bursts are kept contiguous, and the number of consecutive bursts a source may win is bounded.
module mem_req_arbiter #(
    parameter int unsigned ADDRS      = 32,
    parameter int unsigned REQID      = 4,
    parameter int unsigned LOCK_WAIT  = 3,
    parameter int unsigned MAX_BURSTS = 4,
    parameter int unsigned READ_FIRST = 1
) (
    input logic              clock,
    input logic              reset,
    mem_req_arbiter_if.slave bus
);
    localparam int unsigned WW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam int unsigned BW = $clog2(MAX_BURSTS + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_WAIT - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURSTS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t           state;
    state_t           grant;
    logic [WW-1:0]    wait_cnt;
    logic [BW-1:0]    burst_cnt;
    logic             wr_block;
    logic             rd_block;
    logic             req_mux;
    logic             wrn_mux;
    logic             seq_mux;
    logic [REQID-1:0] id_mux;
    logic [ADDRS-1:0] addr_mux;

    // Holding reset forces the idle view so nothing is accepted while reset is high.
    assign grant = reset ? ST_IDLE : state;

    // A new-burst head is withheld once the owner has used up its quota and the other side waits.
    assign wr_block = bus.wr_store_i & ~bus.wr_seq_i & bus.rd_fetch_i & (burst_cnt >= BURST_MAX);
    assign rd_block = bus.rd_fetch_i & ~bus.rd_seq_i & bus.wr_store_i & (burst_cnt >= BURST_MAX);

    always_comb begin
        req_mux  = 1'b0;
        wrn_mux  = 1'b0;
        seq_mux  = 1'b0;
        id_mux   = '0;
        addr_mux = '0;
        case (grant)
            ST_WRITE: begin
                req_mux  = bus.wr_store_i & ~wr_block;
                wrn_mux  = 1'b1;
                seq_mux  = bus.wr_seq_i;
                id_mux   = bus.wr_id_i;
                addr_mux = bus.wr_addr_i;
            end
            ST_READ: begin
                req_mux  = bus.rd_fetch_i & ~rd_block;
                seq_mux  = bus.rd_seq_i;
                id_mux   = bus.rd_id_i;
                addr_mux = bus.rd_addr_i;
            end
            default: ;
        endcase
    end

    assign bus.ctl_req_o   = req_mux;
    assign bus.ctl_wrn_o   = wrn_mux;
    assign bus.ctl_seq_o   = seq_mux;
    assign bus.ctl_id_o    = id_mux;
    assign bus.ctl_addr_o  = addr_mux;
    assign bus.wr_accept_o = (grant == ST_WRITE) & req_mux & bus.ctl_rdy_i;
    assign bus.rd_accept_o = (grant == ST_READ) & req_mux & bus.ctl_rdy_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt  <= '0;
                    burst_cnt <= '0;
                    if (bus.rd_fetch_i && (READ_FIRST != 0 || !bus.wr_store_i)) begin
                        state <= ST_READ;
                    end else if (bus.wr_store_i) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_block) begin
                        state     <= ST_READ;
                        wait_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (bus.ctl_rdy_i) begin
                        if (bus.wr_store_i) begin
                            wait_cnt <= '0;
                            if (!bus.wr_seq_i && burst_cnt < BURST_MAX) begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            state     <= bus.rd_fetch_i ? ST_READ : ST_IDLE;
                            wait_cnt  <= '0;
                            burst_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_block) begin
                        state     <= ST_WRITE;
                        wait_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (bus.ctl_rdy_i) begin
                        if (bus.rd_fetch_i) begin
                            wait_cnt <= '0;
                            if (!bus.rd_seq_i && burst_cnt < BURST_MAX) begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            state     <= bus.wr_store_i ? ST_WRITE : ST_IDLE;
                            wait_cnt  <= '0;
                            burst_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    wait_cnt  <= '0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a read-first instance, plus a write-first instance for tie-break.
module tb_mem_req_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp;
    int   n_err;

    always #5 clock = ~clock;

    mem_req_arbiter_if #(.ADDRS(32), .REQID(4)) bus ();
    mem_req_arbiter_if #(.ADDRS(32), .REQID(4)) bus_wf ();

    mem_req_arbiter #(
        .ADDRS(32), .REQID(4), .LOCK_WAIT(3), .MAX_BURSTS(4), .READ_FIRST(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    mem_req_arbiter #(
        .ADDRS(32), .REQID(4), .LOCK_WAIT(3), .MAX_BURSTS(4), .READ_FIRST(0)
    ) dut_wf (
        .clock(clock),
        .reset(reset),
        .bus  (bus_wf)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_wr(input logic v, input logic s, input logic [3:0] id,
                            input logic [31:0] a);
        bus.wr_store_i = v;
        bus.wr_seq_i   = s;
        bus.wr_id_i    = id;
        bus.wr_addr_i  = a;
    endtask

    task automatic drive_rd(input logic v, input logic s, input logic [3:0] id,
                            input logic [31:0] a);
        bus.rd_fetch_i = v;
        bus.rd_seq_i   = s;
        bus.rd_id_i    = id;
        bus.rd_addr_i  = a;
    endtask

    task automatic idle_out(input int n);
        drive_wr(1'b0, 1'b0, 4'h0, 32'h0);
        drive_rd(1'b0, 1'b0, 4'h0, 32'h0);
        bus.ctl_rdy_i = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_wr(1'b1, 1'b0, 4'h9, 32'hdead_beef);
        drive_rd(1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        settle();
        n_cmp++; if (bus.ctl_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", bus.ctl_req_o); end
        n_cmp++; if (bus.wr_accept_o !== 1'b0) begin n_err++; $display("FAIL rst_wr_acc got %b want 0", bus.wr_accept_o); end
        n_cmp++; if (bus.rd_accept_o !== 1'b0) begin n_err++; $display("FAIL rst_rd_acc got %b want 0", bus.rd_accept_o); end
        n_cmp++; if (bus.ctl_wrn_o !== 1'b0) begin n_err++; $display("FAIL rst_wrn got %b want 0", bus.ctl_wrn_o); end
        n_cmp++; if (bus.ctl_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", bus.ctl_addr_o); end
        n_cmp++; if (bus.ctl_id_o !== 4'h0) begin n_err++; $display("FAIL rst_id got %h want 0", bus.ctl_id_o); end
        reset = 1'b0;
        idle_out(1);
    endtask

    // Write-only burst of four chunks, then a three-cycle lock before returning to idle.
    task automatic test_write_only();
        drive_wr(1'b1, 1'b0, 4'h5, 32'h1000);
        settle();
        n_cmp++; if (bus.wr_accept_o !== 1'b0) begin n_err++; $display("FAIL wo_gap_acc got %b want 0", bus.wr_accept_o); end
        n_cmp++; if (bus.ctl_req_o !== 1'b0) begin n_err++; $display("FAIL wo_gap_req got %b want 0", bus.ctl_req_o); end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive_wr(1'b1, k != 0, 4'h5, 32'h1000 + 32'(k * 16));
            settle();
            n_cmp++; if (bus.wr_accept_o !== 1'b1) begin n_err++; $display("FAIL wo_acc%0d got %b want 1", k, bus.wr_accept_o); end
            n_cmp++; if (bus.ctl_wrn_o !== 1'b1) begin n_err++; $display("FAIL wo_wrn%0d got %b want 1", k, bus.ctl_wrn_o); end
            n_cmp++; if (bus.ctl_addr_o !== 32'h1000 + 32'(k * 16)) begin n_err++; $display("FAIL wo_addr%0d got %h want %h", k, bus.ctl_addr_o, 32'h1000 + 32'(k * 16)); end
            n_cmp++; if (bus.ctl_seq_o !== (k != 0)) begin n_err++; $display("FAIL wo_seq%0d got %b want %b", k, bus.ctl_seq_o, k != 0); end
            tick();
        end
        drive_wr(1'b0, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (bus.ctl_wrn_o !== 1'b1) begin n_err++; $display("FAIL wo_lock%0d wrn got %b want 1", i, bus.ctl_wrn_o); end
            tick();
        end
        settle();
        n_cmp++; if (bus.ctl_wrn_o !== 1'b0) begin n_err++; $display("FAIL wo_back_idle wrn got %b want 0", bus.ctl_wrn_o); end
        idle_out(1);
    endtask

    task automatic test_tie_break();
        drive_wr(1'b1, 1'b0, 4'h1, 32'h4000);
        drive_rd(1'b1, 1'b0, 4'h2, 32'h5000);
        bus_wf.wr_store_i = 1'b1; bus_wf.wr_seq_i = 1'b0; bus_wf.wr_id_i = 4'h1; bus_wf.wr_addr_i = 32'h4000;
        bus_wf.rd_fetch_i = 1'b1; bus_wf.rd_seq_i = 1'b0; bus_wf.rd_id_i = 4'h2; bus_wf.rd_addr_i = 32'h5000;
        settle();
        n_cmp++; if (bus.rd_accept_o !== 1'b0) begin n_err++; $display("FAIL tie_gap_rd got %b want 0", bus.rd_accept_o); end
        n_cmp++; if (bus_wf.wr_accept_o !== 1'b0) begin n_err++; $display("FAIL tie_gap_wf_wr got %b want 0", bus_wf.wr_accept_o); end
        tick();
        settle();
        n_cmp++; if (bus.rd_accept_o !== 1'b1) begin n_err++; $display("FAIL tie_rf_rd got %b want 1", bus.rd_accept_o); end
        n_cmp++; if (bus.wr_accept_o !== 1'b0) begin n_err++; $display("FAIL tie_rf_wr got %b want 0", bus.wr_accept_o); end
        n_cmp++; if (bus.ctl_addr_o !== 32'h5000) begin n_err++; $display("FAIL tie_rf_addr got %h want 5000", bus.ctl_addr_o); end
        n_cmp++; if (bus_wf.wr_accept_o !== 1'b1) begin n_err++; $display("FAIL tie_wf_wr got %b want 1", bus_wf.wr_accept_o); end
        n_cmp++; if (bus_wf.rd_accept_o !== 1'b0) begin n_err++; $display("FAIL tie_wf_rd got %b want 0", bus_wf.rd_accept_o); end
        bus_wf.wr_store_i = 1'b0;
        bus_wf.rd_fetch_i = 1'b0;
        idle_out(5);
    endtask

    // A write that arrives mid read-burst must wait for the burst and its lock window.
    task automatic test_read_lock();
        drive_rd(1'b1, 1'b0, 4'h3, 32'h6000);
        settle();
        tick();
        for (int k = 0; k < 4; k++) begin
            drive_rd(1'b1, k != 0, 4'h3, 32'h6000 + 32'(k * 16));
            if (k > 0) drive_wr(1'b1, 1'b0, 4'h4, 32'h7000);
            settle();
            n_cmp++; if (bus.rd_accept_o !== 1'b1) begin n_err++; $display("FAIL rl_rd_acc%0d got %b want 1", k, bus.rd_accept_o); end
            n_cmp++; if (bus.wr_accept_o !== 1'b0) begin n_err++; $display("FAIL rl_wr_acc%0d got %b want 0", k, bus.wr_accept_o); end
            tick();
        end
        drive_rd(1'b0, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (bus.wr_accept_o !== 1'b0) begin n_err++; $display("FAIL rl_lock%0d wr_acc got %b want 0", i, bus.wr_accept_o); end
            tick();
        end
        settle();
        n_cmp++; if (bus.wr_accept_o !== 1'b1) begin n_err++; $display("FAIL rl_wr_after got %b want 1", bus.wr_accept_o); end
        n_cmp++; if (bus.ctl_addr_o !== 32'h7000) begin n_err++; $display("FAIL rl_wr_addr got %h want 7000", bus.ctl_addr_o); end
        idle_out(5);
    endtask

    // Back-to-back single-chunk bursts from both sides alternate every four bursts.
    task automatic test_starvation();
        logic exp_w;
        logic exp_r;
        drive_wr(1'b1, 1'b0, 4'h6, 32'h8000);
        settle();
        tick();
        drive_rd(1'b1, 1'b0, 4'h7, 32'h9000);
        for (int c = 1; c <= 14; c++) begin
            exp_w = (c <= 4) || (c >= 11);
            exp_r = (c >= 6) && (c <= 9);
            settle();
            n_cmp++; if (bus.wr_accept_o !== exp_w) begin n_err++; $display("FAIL sv_wr_c%0d got %b want %b", c, bus.wr_accept_o, exp_w); end
            n_cmp++; if (bus.rd_accept_o !== exp_r) begin n_err++; $display("FAIL sv_rd_c%0d got %b want %b", c, bus.rd_accept_o, exp_r); end
            tick();
        end
        idle_out(5);
    endtask

    task automatic test_rdy_stall();
        drive_wr(1'b1, 1'b0, 4'h7, 32'h2000);
        settle();
        tick();
        settle();
        n_cmp++; if (bus.wr_accept_o !== 1'b1) begin n_err++; $display("FAIL st_first got %b want 1", bus.wr_accept_o); end
        tick();
        drive_wr(1'b1, 1'b1, 4'h7, 32'h2010);
        drive_rd(1'b1, 1'b0, 4'h8, 32'h3000);
        bus.ctl_rdy_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            n_cmp++; if (bus.wr_accept_o !== 1'b0 || bus.rd_accept_o !== 1'b0) begin n_err++; $display("FAIL st_acc%0d got %b%b want 00", i, bus.wr_accept_o, bus.rd_accept_o); end
            n_cmp++; if (bus.ctl_addr_o !== 32'h2010) begin n_err++; $display("FAIL st_addr%0d got %h want 2010", i, bus.ctl_addr_o); end
            n_cmp++; if (bus.ctl_id_o !== 4'h7 || bus.ctl_req_o !== 1'b1) begin n_err++; $display("FAIL st_cmd%0d got id %h req %b want id 7 req 1", i, bus.ctl_id_o, bus.ctl_req_o); end
            tick();
        end
        bus.ctl_rdy_i = 1'b1;
        settle();
        n_cmp++; if (bus.wr_accept_o !== 1'b1) begin n_err++; $display("FAIL st_resume got %b want 1", bus.wr_accept_o); end
        n_cmp++; if (bus.ctl_wrn_o !== 1'b1) begin n_err++; $display("FAIL st_resume_wrn got %b want 1", bus.ctl_wrn_o); end
        idle_out(6);
    endtask

    task automatic test_reset_mid();
        drive_rd(1'b1, 1'b0, 4'h3, 32'hA000);
        settle();
        tick();
        settle();
        n_cmp++; if (bus.rd_accept_o !== 1'b1) begin n_err++; $display("FAIL rm_pre got %b want 1", bus.rd_accept_o); end
        tick();
        reset = 1'b1;
        settle();
        n_cmp++; if (bus.rd_accept_o !== 1'b0) begin n_err++; $display("FAIL rm_during_acc got %b want 0", bus.rd_accept_o); end
        n_cmp++; if (bus.ctl_req_o !== 1'b0 || bus.ctl_addr_o !== 32'h0) begin n_err++; $display("FAIL rm_during_cmd got req %b addr %h want 0 0", bus.ctl_req_o, bus.ctl_addr_o); end
        tick();
        reset = 1'b0;
        settle();
        n_cmp++; if (bus.rd_accept_o !== 1'b0 || bus.ctl_req_o !== 1'b0) begin n_err++; $display("FAIL rm_idle got acc %b req %b want 0 0", bus.rd_accept_o, bus.ctl_req_o); end
        n_cmp++; if (bus.ctl_id_o !== 4'h0) begin n_err++; $display("FAIL rm_idle_id got %h want 0", bus.ctl_id_o); end
        tick();
        settle();
        n_cmp++; if (bus.rd_accept_o !== 1'b1) begin n_err++; $display("FAIL rm_regrant got %b want 1", bus.rd_accept_o); end
        idle_out(5);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.ctl_rdy_i = 1'b1;
        bus_wf.ctl_rdy_i = 1'b1;
        bus_wf.wr_store_i = 1'b0; bus_wf.wr_seq_i = 1'b0; bus_wf.wr_id_i = 4'h0; bus_wf.wr_addr_i = 32'h0;
        bus_wf.rd_fetch_i = 1'b0; bus_wf.rd_seq_i = 1'b0; bus_wf.rd_id_i = 4'h0; bus_wf.rd_addr_i = 32'h0;
        drive_wr(1'b0, 1'b0, 4'h0, 32'h0);
        drive_rd(1'b0, 1'b0, 4'h0, 32'h0);
        test_reset();
        test_write_only();
        test_tie_break();
        test_read_lock();
        test_starvation();
        test_rdy_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
